multi_pwm: RTL
==============

MULTI_PWM -- requirements
Module: multi_pwm

Interface
REQ-001 Parameter WIDTH, default 10, resolution in bits of the PWM counter and of each duty value.
REQ-002 Parameter CHANNELS, default 4, number of independent PWM outputs sharing one period counter.
REQ-003 Parameter PRESCALE, default 16, number of PWM periods between ramp steps; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  count enable; when low, PWM timing freezes.
REQ-007 wr_vld  input  1  duty/mode write request.
REQ-008 wr_rdy  output  1  write may be accepted this cycle.
REQ-009 wr_ch  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-010 wr_duty  input  WIDTH  new duty, or ramp start point.
REQ-011 wr_mode  input  2  00 static, 01 sawtooth, 10 triangle, 11 treated as static.
REQ-012 pwm_out  output  CHANNELS  registered PWM outputs, one bit per channel.
REQ-013 period_start  output  1  registered pulse marking the first cycle of each period.

Function
REQ-014 Shared counter cnt (WIDTH bits) increments by 1 on each clk edge with en=1 and wraps from 2^WIDTH-1 to 0; a boundary is an edge with en=1 and cnt=2^WIDTH-1.
REQ-015 Next pwm_out[i] = (cnt < active[i]); the update occurs only on edges with en=1; latency is 1 cycle from cnt to pwm_out.
REQ-016 active=0 gives a constantly low output; active=2^WIDTH-1 gives an output that is high for all but one cycle per period.
REQ-017 Next period_start = en && (cnt==0), updated only when en=1, so it aligns with the pwm_out sample for cnt=0.
REQ-018 Each channel holds the registers active[i], mode[i], dir[i] (0=up), pend[i], pend_duty[i] and pend_mode[i].
REQ-019 wr_rdy = !rst && (wr_ch < CHANNELS) && !pend[wr_ch], and is combinational.
REQ-020 A write is accepted when wr_vld && wr_rdy; pend_duty, pend_mode and pend of that channel are then set; an out-of-range wr_ch is never accepted.
REQ-021 Writes are accepted regardless of en.
REQ-022 At a boundary, every channel with pend=1 loads active<=pend_duty, mode<=pend_mode and dir<=up, and clears pend; the first compare at cnt=0 uses the new value.
REQ-023 A write accepted on a boundary edge lands in pending and transfers at the next boundary, not the current one.
REQ-024 Prescaler pcnt (8 bits) increments at each boundary; at the boundary where pcnt==PRESCALE-1 it returns to 0 and asserts a ramp tick.
REQ-025 On a ramp tick, each channel with pend=0 steps: static holds; sawtooth does active+1 with wrap from 2^WIDTH-1 to 0.
REQ-026 Triangle step: with dir up, active+1, and when the result is 2^WIDTH-1, dir becomes down.
REQ-027 Triangle step: with dir down, active-1, and when the result is 0, dir becomes up.
REQ-028 A pending load has priority over a ramp step on the same boundary; the prescaler runs unaffected.
REQ-029 While en=0, cnt, pcnt, active, mode, dir, pwm_out and period_start all hold.

Reset
REQ-030 While rst=1 at an edge: cnt=0, pcnt=0, and for all channels active=0, mode=00, dir=up, pend=0; pwm_out=0, period_start=0.
REQ-031 wr_rdy is 0 throughout reset.
REQ-032 Reset mid-period discards pending writes and ramp state; operation resumes at cnt=0 on the first edge after rst falls.

Verification (WIDTH=4, CHANNELS=4, PRESCALE=2, en=1 unless stated)
REQ-033 After reset, write ch0 duty=5 mode=00 -> from the next boundary, pwm_out[0] is high 5 cycles then low 11 per 16-cycle period; period_start pulses every 16 cycles.
REQ-034 Write ch1 twice within one period -> the second write sees wr_rdy=0 until the boundary edge and is accepted on the following cycle.
REQ-035 ch2 mode=01 duty=14 -> per-period active 14,14,15,15,0,0,1 (the tick phase depends on pcnt alignment).
REQ-036 ch3 mode=10 duty=14 -> active 14,14,15,15,14,14,13; ch3 duty=0 mode=10 stays up: 0,0,1,1.
REQ-037 Drop en for 7 cycles mid-period -> pwm_out, period_start and cnt are frozen; on resume the period completes with correct high-count.
REQ-038 Assert rst with pend[0]=1 at cnt=9 -> pwm_out=0 next cycle; after release the pending write never takes effect; wr_rdy=0 during rst.

Source files
------------

// File: rtl/multi_pwm.sv
// rtl/multi_pwm.sv - multi-channel PWM generator with shared period counter and per-channel duty ramping
module multi_pwm #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 16,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_vld,
  output logic                wr_rdy,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic [1:0]          wr_mode,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  localparam logic             DIR_UP     = 1'b0;
  localparam logic             DIR_DOWN   = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_TOP_M1 = CNT_MAX - 1'b1;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [CW:0]      CH_LIMIT   = (CW+1)'(CHANNELS);
  localparam logic [7:0]       PCNT_LAST  = 8'(PRESCALE - 1);

  // Shared timing state
  logic [WIDTH-1:0] cnt;
  logic [7:0]       pcnt;

  // Per-channel state: live duty/mode/direction plus a one-deep pending slot
  logic [WIDTH-1:0]    active    [CHANNELS];
  mode_t               mode      [CHANNELS];
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] pend;
  logic [WIDTH-1:0]    pend_duty [CHANNELS];
  mode_t               pend_mode [CHANNELS];

  // Ramp step candidates, applied only on a ramp tick
  logic [WIDTH-1:0]    step_active [CHANNELS];
  logic [CHANNELS-1:0] step_dir;

  logic boundary;
  logic ramp_tick;
  logic ch_valid;
  logic sel_pend;
  logic wr_acc;

  // Look up the pending flag of the addressed channel without indexing out of range
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ({1'b0, wr_ch} == (CW+1)'(i)) begin
        sel_pend = pend[i];
      end
    end
  end

  assign ch_valid  = ({1'b0, wr_ch} < CH_LIMIT);
  assign wr_rdy    = !rst && ch_valid && !sel_pend;
  assign wr_acc    = wr_vld && wr_rdy;
  assign boundary  = en && (cnt == CNT_MAX);
  assign ramp_tick = boundary && (pcnt == PCNT_LAST);

  // Compute each channel's next ramp value and direction from its mode
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      step_active[i] = active[i];
      step_dir[i]    = dir[i];
      case (mode[i])
        MODE_SAW: begin
          step_active[i] = active[i] + 1'b1;
        end
        MODE_TRI: begin
          if (dir[i] == DIR_UP) begin
            step_active[i] = active[i] + 1'b1;
            if (active[i] == CNT_TOP_M1) begin
              step_dir[i] = DIR_DOWN;
            end
          end else begin
            step_active[i] = active[i] - 1'b1;
            if (active[i] == CNT_ONE) begin
              step_dir[i] = DIR_UP;
            end
          end
        end
        default: begin
          step_active[i] = active[i];
        end
      endcase
    end
  end

  // Period counter and ramp prescaler; both freeze while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= CNT_ZERO;
      pcnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (boundary) begin
        pcnt <= ramp_tick ? 8'd0 : pcnt + 8'd1;
      end
    end
  end

  // Channel state: pending loads win over ramp steps at a boundary; new writes land in pending
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i]    <= CNT_ZERO;
        mode[i]      <= MODE_STATIC;
        dir[i]       <= DIR_UP;
        pend[i]      <= 1'b0;
        pend_duty[i] <= CNT_ZERO;
        pend_mode[i] <= MODE_STATIC;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary && pend[i]) begin
          active[i] <= pend_duty[i];
          mode[i]   <= pend_mode[i];
          dir[i]    <= DIR_UP;
          pend[i]   <= 1'b0;
        end else if (ramp_tick) begin
          active[i] <= step_active[i];
          dir[i]    <= step_dir[i];
        end
        if (wr_acc && ({1'b0, wr_ch} == (CW+1)'(i))) begin
          pend[i]      <= 1'b1;
          pend_duty[i] <= wr_duty;
          pend_mode[i] <= mode_t'(wr_mode);
        end
      end
    end
  end

  // Registered compare outputs and period marker, one cycle behind cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (cnt < active[i]);
      end
      period_start <= (cnt == CNT_ZERO);
    end
  end

endmodule
